// File: rtl/cnt_sched_if.sv
// Requester-side bus of the counter scheduler.
// Each requester owns one bit of req/grant and one WIDTH slice of load_val/run_len.
// The master modport is the requester side and the slave modport is the scheduler side.
interface cnt_sched_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
) ();

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] load_val;
  logic [NREQ*WIDTH-1:0] run_len;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic [WIDTH-1:0]      result;

  modport master (
    output req, load_val, run_len,
    input  grant, busy, done, done_id, result
  );

  modport slave (
    input  req, load_val, run_len,
    output grant, busy, done, done_id, result
  );

endinterface

// File: rtl/cnt_sched.sv
// cnt_sched: round-robin scheduler that shares one loadable up-counter
// between NREQ requesters. For each granted job it issues one load strobe,
// then exactly run_len increment strobes, and then returns the final count.
//
// Optional build macro CNT_SCHED_PAUSE_EN adds the pause_i input.
// While pause_i is high in RUN, the increment is withheld and the job is frozen.
// Without the macro, the RUN state never stalls.
module cnt_sched #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  cnt_sched_if.slave       bus,
  output logic             cnt_load_o,
  output logic [WIDTH-1:0] cnt_load_val_o,
  output logic             cnt_inc_o,
  input  logic [WIDTH-1:0] cnt_value_i
`ifdef CNT_SCHED_PAUSE_EN
  ,
  input  logic             pause_i
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   owner_q;
  logic [WIDTH-1:0] remaining_q;
  logic [NREQ-1:0]  grant_q;
  logic             busy_q;
  logic             done_q;
  logic [IDW-1:0]   done_id_q;
  logic [WIDTH-1:0] result_q;
  logic             cnt_load_q;
  logic [WIDTH-1:0] cnt_load_val_q;
  logic             cnt_inc_q;

  logic             sel_valid_d;
  logic [IDW-1:0]   sel_idx_d;
  logic [WIDTH-1:0] sel_load_d;
  logic [WIDTH-1:0] sel_len_d;
  logic [IDW-1:0]   ptr_next_d;
  logic             stall;

`ifdef CNT_SCHED_PAUSE_EN
  assign stall = pause_i;
`else
  assign stall = 1'b0;
`endif

  // Round-robin pick: the first requester at or after ptr_q, wrapping around.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    int idx;
    idx         = 0;
    sel_valid_d = 1'b0;
    sel_idx_d   = '0;
    sel_load_d  = '0;
    sel_len_d   = '0;
    // Walk downward so that the last hit is the one closest to the pointer.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (bus.req[idx]) begin
        sel_valid_d = 1'b1;
        sel_idx_d   = IDW'(idx);
        sel_load_d  = bus.load_val[idx*WIDTH +: WIDTH];
        sel_len_d   = bus.run_len[idx*WIDTH +: WIDTH];
      end
    end
  end

  // Point just past the finishing owner, so it gets the lowest priority next time.
  always_comb begin
    if (owner_q == IDW'(NREQ - 1)) ptr_next_d = '0;
    else                           ptr_next_d = owner_q + 1'b1;
  end

  // Job sequencer. Every output is registered on the state transition that produces it.
  // NOTE: this is sequential state, so it uses only non-blocking assignments.
  // Asynchronous reset clears every register and drops any job in flight without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      owner_q        <= '0;
      remaining_q    <= '0;
      grant_q        <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      done_id_q      <= '0;
      result_q       <= '0;
      cnt_load_q     <= 1'b0;
      cnt_load_val_q <= '0;
      cnt_inc_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel_valid_d) begin
            owner_q        <= sel_idx_d;
            grant_q        <= NREQ'(1) << sel_idx_d;
            cnt_load_val_q <= sel_load_d;
            remaining_q    <= sel_len_d;
            cnt_load_q     <= 1'b1;
            busy_q         <= 1'b1;
            state_q        <= S_LOAD;
          end
        end
        S_LOAD: begin
          cnt_load_q <= 1'b0;
          if (remaining_q == '0) begin
            done_q    <= 1'b1;
            done_id_q <= owner_q;
            state_q   <= S_DONE;
          end else begin
            cnt_inc_q <= 1'b1;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          if (!stall) begin
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == WIDTH'(1)) begin
              cnt_inc_q <= 1'b0;
              done_q    <= 1'b1;
              done_id_q <= owner_q;
              state_q   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
          grant_q  <= '0;
          result_q <= cnt_value_i;
          ptr_q    <= ptr_next_d;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The counter becomes final during the DONE cycle itself.
  // Show it live in DONE, and hold the captured value afterwards.
  assign bus.result     = (state_q == S_DONE) ? cnt_value_i : result_q;
  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.done_id    = done_id_q;
  assign cnt_load_o     = cnt_load_q;
  assign cnt_load_val_o = cnt_load_val_q;
  assign cnt_inc_o      = cnt_inc_q & ~stall;

endmodule
